control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit bus-based CPU datapath.
- Replaces the hand-timed control signals used in bench sequences with a T-state machine.
- Sequences fetch (T0–T2) and the per-opcode execute steps.
- Reads IR and CON from the datapath; drives every register-enable, bus-out, register-select and memory strobe.

Parameters:
IR_WIDTH, 32, instruction register width; opcode is IR[IR_WIDTH-1 -: 5]
HALT_ON_ILLEGAL, 0, 1 = an undefined opcode enters HALT; 0 = it is treated as nop

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  synchronous active-low reset
IR  in  IR_WIDTH  instruction register contents
CON  in  1  branch condition flop output
HIin LOin PCin MDRin Zin Yin MARin IRin CONin OUTPORTin  out  1 each  register load enables
HIout LOout ZHIout ZLOout PCout MDRout INPORTout Cout BAout  out  1 each  bus drivers
Gra Grb Grc Rin Rout  out  1 each  register-file select/enable
R15in  out  1  link-register write (jal)
Read write IncPC  out  1 each  memory/PC strobes
alu_op  out  5  ALU function; meaningful only while Zin=1
Run  out  1  1 = executing; 0 = halted
illegal  out  1  one-cycle pulse at T3 on an undefined opcode

Behaviour:
- States: RST, T0..T7, HALT.
- Outputs are a pure decode of state + latched opcode.
- Each step asserts its signals for exactly one full clock cycle; all unlisted outputs are 0.
- Reset:
  - Resetn=0 at a posedge → state=RST, regardless of current state, including mid-instruction.
  - In RST all outputs are 0 except Run=1.
  - RST→T0 on the first edge with Resetn=1.
  - Any partially executed instruction is abandoned; no write strobe is issued after reset is sampled.
- Fetch:
  - T0: PCout MARin.
  - T1: Read MDRin PCin IncPC.
  - T2: MDRout IRin.
  - Opcode is latched at the T2→T3 edge from the IR input.
- Execute (opcode → steps; the last listed step returns to T0):
  - add 00011 / sub 00100 / and 00101 / or 00110: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=opcode; T5 ZLOout Gra Rin.
  - addi 01100 / ldi 00001: T3 Grb BAout Yin; T4 Cout Zin alu_op=00011; T5 ZLOout Gra Rin.
  - ld 00000: T3/T4 as ldi; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st 00010: T3/T4 as ldi; T5 ZLOout MARin; T6 Gra Rout MDRin; T7 write.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin alu_op=00011; T6 ZLOout PCin only if CON=1, otherwise T6 asserts nothing.
  - jr 10100: T3 Gra Rout PCin.
  - jal 10011: T3 PCout R15in; T4 Gra Rout PCin.
  - in 10110: T3 INPORTout Gra Rin.
  - out 10111: T3 Gra Rout OUTPORTin.
  - mfhi 11000: T3 HIout Gra Rin.
  - mflo 11001: T3 LOout Gra Rin.
  - nop 11010: T3 nothing → T0.
  - halt 11011: T3 → HALT.
- HALT:
  - All outputs 0, Run=0.
  - Leaves only via Resetn=0.
- Undefined opcode:
  - illegal=1 in T3.
  - Then T0 when HALT_ON_ILLEGAL=0, else HALT.
- CON is sampled only during T6 of br; CON changes at any other time have no effect.
- No two bus drivers are ever asserted in the same cycle. An assertion in the bench flags a violation.

Test Plan:
- Reset then release; IR held at nop (11010): outputs all 0 in RST; then T0 PCout/MARin, T1 Read/MDRin/PCin/IncPC, T2 MDRout/IRin, T3 idle, back to T0 → 4-cycle loop.
- add (00011): T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=00011; T5 ZLOout Gra Rin; next instruction fetch begins at cycle 6.
- ld (00000) and st (00010): 8 cycles each.
  - ld: Read high in T1 and T6; Gra Rin in T7.
  - st: write high only in T7; MDRin high in T1 and T6.
- br (10010) with CON=1 vs CON=0: PCin asserted with ZLOout in T6 only for CON=1. Both take 7 cycles.
- jal (10011): T3 PCout+R15in; T4 Gra+Rout+PCin. Then halt (11011): Run falls to 0 and stays 0 for 20 cycles.
- Resetn pulled low during T5 of st: next state RST; write is never asserted. Also check an undefined opcode 11111 with HALT_ON_ILLEGAL=0: illegal pulses for 1 cycle in T3, then T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the 32-bit bus CPU: fetch in T0-T2, per-opcode execute in T3-T7.
// Control outputs are registered from the decode of the next state, so each step's signals hold for one full clock.
module control_sequencer #(
  parameter int IR_WIDTH        = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                CON,
  output logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  output logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout,
  output logic Gra, Grb, Grc, Rin, Rout,
  output logic R15in,
  output logic Read, write, IncPC,
  output logic [4:0] alu_op,
  output logic Run,
  output logic illegal
);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b10011, OP_JR   = 5'b10100, OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef struct packed {
    logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout;
    logic Gra, Grb, Grc, Rin, Rout, R15in;
    logic Read, write, IncPC;
    logic [4:0] alu_op;
    logic Run, illegal;
    logic br_t6;  // branch write-back step; gated by live CON at the output
  } ctl_t;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  ctl_t       ctl_q;

  logic unused_ir;
  assign unused_ir = ^IR[IR_WIDTH-6:0];

  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_LDI, OP_LD, OP_ST};
  endfunction

  function automatic logic is_known(input logic [4:0] op);
    return is_alu(op) || is_imm(op) ||
           (op inside {OP_BR, OP_JAL, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT});
  endfunction

  function automatic ctl_t decode(input state_e s, input logic [4:0] op);
    ctl_t c;
    c = '0;
    c.Run = (s != S_HALT);
    case (s)
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; end
      S_T1: begin c.Read = 1'b1; c.MDRin = 1'b1; c.PCin = 1'b1; c.IncPC = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3: begin
        if (is_alu(op))       begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
        else if (is_imm(op))  begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
        else case (op)
          OP_BR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
          OP_JR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
          OP_JAL:  begin c.PCout = 1'b1; c.R15in = 1'b1; end
          OP_IN:   begin c.INPORTout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_OUT:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.OUTPORTin = 1'b1; end
          OP_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_NOP, OP_HALT: ;
          default: c.illegal = 1'b1;
        endcase
      end
      S_T4: begin
        if (is_alu(op))         begin c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.alu_op = op; end
        else if (is_imm(op))    begin c.Cout = 1'b1; c.Zin = 1'b1; c.alu_op = OP_ADD; end
        else if (op == OP_BR)   begin c.PCout = 1'b1; c.Yin = 1'b1; end
        else if (op == OP_JAL)  begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
      end
      S_T5: begin
        if (op inside {OP_LD, OP_ST}) begin c.ZLOout = 1'b1; c.MARin = 1'b1; end
        else if (op == OP_BR)         begin c.Cout = 1'b1; c.Zin = 1'b1; c.alu_op = OP_ADD; end
        else                          begin c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
      end
      S_T6: begin
        if (op == OP_LD)      begin c.Read = 1'b1; c.MDRin = 1'b1; end
        else if (op == OP_ST) begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
        else                  c.br_t6 = 1'b1;
      end
      S_T7: begin
        if (op == OP_LD) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        else             c.write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  begin state_d = S_T3; op_d = IR[IR_WIDTH-1 -: 5]; end
      S_T3: begin
        if (!is_known(op_q))    state_d = HALT_ON_ILLEGAL ? S_HALT : S_T0;
        else if (op_q == OP_HALT) state_d = S_HALT;
        else if (op_q inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP}) state_d = S_T0;
        else                    state_d = S_T4;
      end
      S_T4:   state_d = (op_q == OP_JAL) ? S_T0 : S_T5;
      S_T5:   state_d = (op_q inside {OP_LD, OP_ST, OP_BR}) ? S_T6 : S_T0;
      S_T6:   state_d = (op_q == OP_BR) ? S_T0 : S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_RST;
      op_q    <= '0;
      ctl_q   <= decode(S_RST, '0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctl_q   <= decode(state_d, op_d);
    end
  end

  assign HIin      = ctl_q.HIin;
  assign LOin      = ctl_q.LOin;
  assign PCin      = ctl_q.PCin | (ctl_q.br_t6 & CON);
  assign MDRin     = ctl_q.MDRin;
  assign Zin       = ctl_q.Zin;
  assign Yin       = ctl_q.Yin;
  assign MARin     = ctl_q.MARin;
  assign IRin      = ctl_q.IRin;
  assign CONin     = ctl_q.CONin;
  assign OUTPORTin = ctl_q.OUTPORTin;
  assign HIout     = ctl_q.HIout;
  assign LOout     = ctl_q.LOout;
  assign ZHIout    = ctl_q.ZHIout;
  assign ZLOout    = ctl_q.ZLOout | (ctl_q.br_t6 & CON);
  assign PCout     = ctl_q.PCout;
  assign MDRout    = ctl_q.MDRout;
  assign INPORTout = ctl_q.INPORTout;
  assign Cout      = ctl_q.Cout;
  assign BAout     = ctl_q.BAout;
  assign Gra       = ctl_q.Gra;
  assign Grb       = ctl_q.Grb;
  assign Grc       = ctl_q.Grc;
  assign Rin       = ctl_q.Rin;
  assign Rout      = ctl_q.Rout;
  assign R15in     = ctl_q.R15in;
  assign Read      = ctl_q.Read;
  assign write     = ctl_q.write;
  assign IncPC     = ctl_q.IncPC;
  assign alu_op    = ctl_q.alu_op;
  assign Run       = ctl_q.Run;
  assign illegal   = ctl_q.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle control words are queued per instruction and popped each cycle.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Resetn;
  logic [31:0] IR;
  logic CON;
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout, R15in, Read, write, IncPC;
  logic [4:0] alu_op;
  logic Run, illegal;

  control_sequencer #(.IR_WIDTH(32), .HALT_ON_ILLEGAL(1'b0)) dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .CON(CON),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .R15in(R15in),
    .Read(Read), .write(write), .IncPC(IncPC), .alu_op(alu_op), .Run(Run), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  logic [34:0] obs;
  assign obs = {Run, illegal, alu_op, HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin,
                OUTPORTin, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout,
                Gra, Grb, Grc, Rin, Rout, R15in, Read, write, IncPC};

  localparam logic [34:0] INCPC = 35'd1 << 0,  WRITE = 35'd1 << 1,  READ = 35'd1 << 2;
  localparam logic [34:0] R15IN = 35'd1 << 3,  ROUT  = 35'd1 << 4,  RIN  = 35'd1 << 5;
  localparam logic [34:0] GRC   = 35'd1 << 6,  GRB   = 35'd1 << 7,  GRA  = 35'd1 << 8;
  localparam logic [34:0] BAOUT = 35'd1 << 9,  COUT  = 35'd1 << 10, INPORTOUT = 35'd1 << 11;
  localparam logic [34:0] MDROUT = 35'd1 << 12, PCOUT = 35'd1 << 13, ZLOOUT = 35'd1 << 14;
  localparam logic [34:0] LOOUT = 35'd1 << 16, HIOUT = 35'd1 << 17, OUTPORTIN = 35'd1 << 18;
  localparam logic [34:0] CONIN = 35'd1 << 19, IRIN  = 35'd1 << 20, MARIN = 35'd1 << 21;
  localparam logic [34:0] YIN   = 35'd1 << 22, ZIN   = 35'd1 << 23, MDRIN = 35'd1 << 24;
  localparam logic [34:0] PCIN  = 35'd1 << 25, ILL   = 35'd1 << 33, RUN   = 35'd1 << 34;

  function automatic logic [34:0] aluf(input logic [4:0] op);
    return {2'b00, op, 28'd0};
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  logic [34:0] sb_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [34:0] v);
    sb_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
    else chk(tag_q.pop_front(), {29'd0, obs}, {29'd0, sb_q.pop_front()});
  endtask

  task automatic drain();
    while (sb_q.size() > 0) tick();
  endtask

  task automatic load(input logic [4:0] op, input string n);
    IR = {op, 27'($urandom)};
    push({n, ".T0"}, RUN | PCOUT | MARIN);
    push({n, ".T1"}, RUN | READ | MDRIN | PCIN | INCPC);
    push({n, ".T2"}, RUN | MDROUT | IRIN);
  endtask

  task automatic run3(input logic [4:0] op, input string n, input logic [34:0] t3);
    load(op, n);
    push({n, ".T3"}, RUN | t3);
    drain();
  endtask

  task automatic alu_rrr(input logic [4:0] op, input string n);
    load(op, n);
    push({n, ".T3"}, RUN | GRB | ROUT | YIN);
    push({n, ".T4"}, RUN | GRC | ROUT | ZIN | aluf(op));
    push({n, ".T5"}, RUN | ZLOOUT | GRA | RIN);
    drain();
  endtask

  task automatic imm_front(input logic [4:0] op, input string n);
    load(op, n);
    push({n, ".T3"}, RUN | GRB | BAOUT | YIN);
    push({n, ".T4"}, RUN | COUT | ZIN | aluf(5'b00011));
  endtask

  // CON is held at con_early through T0-T5 and switched to con_t6 just before T6
  task automatic br_test(input logic con_early, input logic con_t6, input string n);
    CON = con_early;
    load(5'b10010, n);
    push({n, ".T3"}, RUN | GRA | ROUT | CONIN);
    push({n, ".T4"}, RUN | PCOUT | YIN);
    push({n, ".T5"}, RUN | COUT | ZIN | aluf(5'b00011));
    push({n, ".T6"}, con_t6 ? (RUN | ZLOOUT | PCIN) : RUN);
    repeat (6) tick();
    CON = con_t6;
    tick();
    CON = 1'b0;
  endtask

  always @(negedge Clock)
    assert ($onehot0({HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout, Rout}))
      else $error("bus contention: more than one bus driver asserted");

  initial begin
    Resetn = 1'b0;
    CON    = 1'b0;
    IR     = {5'b11010, 27'd0};
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_state", {29'd0, obs}, {29'd0, RUN});
    Resetn = 1'b1;

    run3(5'b11010, "nop0", '0);
    run3(5'b11010, "nop1", '0);
    alu_rrr(5'b00011, "add");
    alu_rrr(5'b00100, "sub");
    alu_rrr(5'b00110, "or");

    imm_front(5'b01100, "addi");
    push("addi.T5", RUN | ZLOOUT | GRA | RIN);
    drain();

    imm_front(5'b00000, "ld");
    push("ld.T5", RUN | ZLOOUT | MARIN);
    push("ld.T6", RUN | READ | MDRIN);
    push("ld.T7", RUN | MDROUT | GRA | RIN);
    drain();

    imm_front(5'b00010, "st");
    push("st.T5", RUN | ZLOOUT | MARIN);
    push("st.T6", RUN | GRA | ROUT | MDRIN);
    push("st.T7", RUN | WRITE);
    drain();

    br_test(1'b1, 1'b1, "br_taken");
    br_test(1'b0, 1'b0, "br_not");
    br_test(1'b1, 1'b0, "br_late0");
    br_test(1'b0, 1'b1, "br_late1");

    run3(5'b10100, "jr",   GRA | ROUT | PCIN);
    run3(5'b10110, "in",   INPORTOUT | GRA | RIN);
    run3(5'b10111, "out",  GRA | ROUT | OUTPORTIN);
    run3(5'b11000, "mfhi", HIOUT | GRA | RIN);
    run3(5'b11001, "mflo", LOOUT | GRA | RIN);
    run3(5'b11111, "undef", ILL);
    run3(5'b11010, "nop_after_undef", '0);

    load(5'b10011, "jal");
    push("jal.T3", RUN | PCOUT | R15IN);
    push("jal.T4", RUN | GRA | ROUT | PCIN);
    drain();
    run3(5'b11011, "halt", '0);
    for (int i = 0; i < 20; i++) push("halted", '0);
    drain();

    Resetn = 1'b0;
    push("rst_from_halt", RUN);
    drain();
    Resetn = 1'b1;

    imm_front(5'b00010, "st_abort");
    push("st_abort.T5", RUN | ZLOOUT | MARIN);
    drain();
    Resetn = 1'b0;
    push("st_abort.rst", RUN);
    push("st_abort.rst2", RUN);
    drain();
    Resetn = 1'b1;
    run3(5'b11010, "nop_after_abort", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
